complex_div: RTL and testbench

Multi-cycle complex-number divider servicing the divide opcode that the combinational ALU does not implement. The core hands it two complex operands (A = A1 + A2·i, B = B1 + B2·i) with a start/busy/done handshake. Both quotient components are returned as 8-bit signed values, along with a divide-by-zero flag. It sits beside the ALU on the same operand buses, and its results feed the same writeback path as Out1/Out2.

---
 rtl/complex_div.sv | 213 +++++++++++++++++++++
 tb/tb_complex_div.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/complex_div.sv
// complex_div: multi-cycle complex divider, Out = A / B with A = A1 + A2*i, B = B1 + B2*i.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   A1, A2, B1, B2    - signed operand components, latched when Start is accepted
//   Start             - request, accepted in IDLE or in the DONE cycle
//   Busy              - operation in flight (state != IDLE)
//   Done              - one-cycle pulse, Out1/Out2/DivZero freshly valid
//   Out1, Out2        - saturated, truncated signed quotient components
//   DivZero           - divisor was 0+0i (quotients forced to 0)
module complex_div #(
  parameter int QW       = 8,
  parameter int DIV_ITER = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [QW-1:0] A1,
  input  logic signed [QW-1:0] A2,
  input  logic signed [QW-1:0] B1,
  input  logic signed [QW-1:0] B2,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic signed [QW-1:0] Out1,
  output logic signed [QW-1:0] Out2,
  output logic                 DivZero
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(DIV_ITER - 1);

  state_t state_q, state_d;
  logic signed [QW-1:0] a1_q, a2_q, b1_q, b2_q, a1_d, a2_d, b1_d, b2_d;
  logic signed [16:0] nr_q, ni_q, nr_d, ni_d;
  logic [15:0] den_q, den_d;
  logic        loaded_q, loaded_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rr_q, ri_q, rr_d, ri_d;   // partial remainders
  logic [15:0] qr_q, qi_q, qr_d, qi_d;   // numerator shifting out / quotient shifting in
  logic        negr_q, negi_q, negr_d, negi_d;
  logic signed [QW-1:0] out1_q, out2_q, out1_d, out2_d;
  logic        dz_q, dz_d;
  logic        accept;

  logic signed [15:0] p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
  logic signed [16:0] nr_c, ni_c;
  logic [15:0] den_c;
  logic [16:0] nr_abs, ni_abs;
  logic [16:0] tr_r, tr_i;
  logic        bit_r, bit_i;
  logic [15:0] rr_nx, ri_nx, qr_nx, qi_nx;

  assign p_ac = 16'(a1_q) * 16'(b1_q);
  assign p_bd = 16'(a2_q) * 16'(b2_q);
  assign p_bc = 16'(a2_q) * 16'(b1_q);
  assign p_ad = 16'(a1_q) * 16'(b2_q);
  assign p_cc = 16'(b1_q) * 16'(b1_q);
  assign p_dd = 16'(b2_q) * 16'(b2_q);
  assign nr_c  = 17'(p_ac) + 17'(p_bd);
  assign ni_c  = 17'(p_bc) - 17'(p_ad);
  assign den_c = $unsigned(p_cc) + $unsigned(p_dd);

  assign nr_abs = nr_q[16] ? 17'(-nr_q) : 17'(nr_q);
  assign ni_abs = ni_q[16] ? 17'(-ni_q) : 17'(ni_q);

  // One restoring step per divider: shift next numerator bit into remainder, subtract if it fits.
  always_comb begin
    tr_r  = {1'b0, rr_q[14:0], qr_q[15]};
    tr_i  = {1'b0, ri_q[14:0], qi_q[15]};
    if (rr_q[15]) tr_r = {rr_q, qr_q[15]};
    if (ri_q[15]) tr_i = {ri_q, qi_q[15]};
    bit_r = (tr_r >= {1'b0, den_q});
    bit_i = (tr_i >= {1'b0, den_q});
    rr_nx = bit_r ? 16'(tr_r - {1'b0, den_q}) : tr_r[15:0];
    ri_nx = bit_i ? 16'(tr_i - {1'b0, den_q}) : tr_i[15:0];
    qr_nx = {qr_q[14:0], bit_r};
    qi_nx = {qi_q[14:0], bit_i};
  end

  function automatic logic [7:0] sat8(input logic neg, input logic [15:0] mag);
    if (neg) return (mag > 16'd128) ? 8'h80 : 8'(-mag);
    else     return (mag > 16'd127) ? 8'h7F : mag[7:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    nr_d     = nr_q;
    ni_d     = ni_q;
    den_d    = den_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    ri_d     = ri_q;
    qr_d     = qr_q;
    qi_d     = qi_q;
    negr_d   = negr_q;
    negi_d   = negi_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    dz_d     = dz_q;
    accept   = 1'b0;
    unique case (state_q)
      S_IDLE: accept = Start;
      S_PREP: begin
        nr_d     = nr_c;
        ni_d     = ni_c;
        den_d    = den_c;
        loaded_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_DIV;
      end
      S_DIV: begin
        // First DIV cycle turns the registered sums into magnitudes and loads both
        // dividers; the following DIV_ITER cycles each retire one quotient bit.
        if (!loaded_q) begin
          loaded_d = 1'b1;
          negr_d   = nr_q[16];
          negi_d   = ni_q[16];
          qr_d     = nr_abs[15:0];
          qi_d     = ni_abs[15:0];
          rr_d     = '0;
          ri_d     = '0;
        end else begin
          rr_d  = rr_nx;
          ri_d  = ri_nx;
          qr_d  = qr_nx;
          qi_d  = qi_nx;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            if (den_q == '0) begin
              out1_d = '0;
              out2_d = '0;
              dz_d   = 1'b1;
            end else begin
              out1_d = sat8(negr_q, qr_nx);
              out2_d = sat8(negi_q, qi_nx);
              dz_d   = 1'b0;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        accept  = Start;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_PREP;
      a1_d    = A1;
      a2_d    = A2;
      b1_d    = B1;
      b2_d    = B2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a1_q     <= '0;
      a2_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      nr_q     <= '0;
      ni_q     <= '0;
      den_q    <= '0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= '0;
      ri_q     <= '0;
      qr_q     <= '0;
      qi_q     <= '0;
      negr_q   <= 1'b0;
      negi_q   <= 1'b0;
      out1_q   <= '0;
      out2_q   <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      nr_q     <= nr_d;
      ni_q     <= ni_d;
      den_q    <= den_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      ri_q     <= ri_d;
      qr_q     <= qr_d;
      qi_q     <= qi_d;
      negr_q   <= negr_d;
      negi_q   <= negi_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      dz_q     <= dz_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = (state_q == S_DONE);
  assign Out1    = out1_q;
  assign Out2    = out2_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: scoreboard bench for complex_div. Stimulus pushes expected
// results (values and Done cycle) computed with plain integer arithmetic; a
// monitor pops and compares on every Done pulse.
module tb_complex_div;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] A1, A2, B1, B2;
  logic              Start;
  logic              Busy, Done, DivZero;
  logic signed [7:0] Out1, Out2;

  typedef struct {
    byte o1;
    byte o2;
    bit  dz;
    int  cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  complex_div #(.QW(8), .DIV_ITER(16)) dut (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2),
    .Start(Start), .Busy(Busy), .Done(Done),
    .Out1(Out1), .Out2(Out2), .DivZero(DivZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int c, input int d, input int done_cyc);
    exp_t e;
    int nr, ni, den, qr, qi;
    nr  = a * c + b * d;
    ni  = b * c - a * d;
    den = c * c + d * d;
    e.cyc = done_cyc;
    if (den == 0) begin
      e.o1 = 0; e.o2 = 0; e.dz = 1'b1;
    end else begin
      qr = nr / den;
      qi = ni / den;
      if (qr > 127) qr = 127;
      if (qr < -128) qr = -128;
      if (qi > 127) qi = 127;
      if (qi < -128) qi = -128;
      e.o1 = byte'(qr); e.o2 = byte'(qi); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every Done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: Done=1 with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("out1", int'(Out1), int'(e.o1));
        chk("out2", int'(Out2), int'(e.o2));
        chk("divzero", int'(DivZero), int'(e.dz));
      end
    end
  end

  // Issue one operation; returns at the edge where Done is expected, so
  // consecutive calls start back-to-back.
  task automatic issue(input byte a, input byte b, input byte c, input byte d);
    int k;
    @(negedge clk);
    A1 = a; A2 = b; B1 = c; B2 = d;
    Start = 1'b1;
    k = cyc + 1;
    sb.push_back(model(a, b, c, d, k + 18));
    @(posedge clk);
    #1;
    Start = 1'b0;
    chk("busy_after_start", int'(Busy), 1);
    repeat (18) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    byte a, b, c, d;
    rst = 1'b1; Start = 1'b0;
    A1 = '0; A2 = '0; B1 = '0; B2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_out1", int'(Out1), 0);
    chk("rst_out2", int'(Out2), 0);
    chk("rst_divzero", int'(DivZero), 0);

    // rst together with Start: Start dropped
    @(negedge clk);
    A1 = 8'sd9; A2 = 8'sd9; B1 = 8'sd1; B2 = 8'sd0;
    rst = 1'b1; Start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; Start = 1'b0;
    chk("rst_start_busy", int'(Busy), 0);

    // Directed cases, issued back-to-back
    issue(8'sd100, 8'sd50, 8'sd1, 8'sd1);
    issue(8'sd5, 8'sd6, 8'sd0, 8'sd0);
    issue(8'sd5, 8'sd6, 8'sd7, 8'sd8);
    issue(-8'sd128, -8'sd128, 8'sd0, 8'sd1);
    issue(-8'sd7, 8'sd0, 8'sd2, 8'sd0);
    issue(8'sd127, 8'sd127, 8'sd1, 8'sd0);
    issue(-8'sd7, 8'sd0, 8'sd2, 8'sd0);

    // Start held high, operands changed at k+3
    @(negedge clk);
    A1 = 8'sd100; A2 = 8'sd50; B1 = 8'sd1; B2 = 8'sd1;
    Start = 1'b1;
    k = cyc + 1;
    sb.push_back(model(100, 50, 1, 1, k + 18));
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    A1 = -8'sd60; A2 = 8'sd33; B1 = 8'sd3; B2 = -8'sd2;
    sb.push_back(model(-60, 33, 3, -2, k + 37));
    repeat (16) @(posedge clk);
    #1;
    Start = 1'b0;
    chk("held_busy_k19", int'(Busy), 1);
    repeat (18) @(posedge clk);

    // Reset mid-operation at k+8
    @(negedge clk);
    A1 = 8'sd50; A2 = 8'sd20; B1 = 8'sd2; B2 = 8'sd1;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_done", int'(Done), 0);
    chk("midrst_out1", int'(Out1), 0);
    chk("midrst_out2", int'(Out2), 0);
    chk("midrst_divzero", int'(DivZero), 0);
    @(posedge clk);
    issue(-8'sd128, 8'sd127, -8'sd3, 8'sd4);

    // Randomized operations, biased toward zero and tiny divisors
    for (int i = 0; i < 24; i++) begin
      a = byte'($urandom);
      b = byte'($urandom);
      c = byte'($urandom);
      d = byte'($urandom);
      case ($urandom_range(0, 3))
        0: begin c = 0; d = 0; end
        1: begin c = byte'($urandom_range(0, 2)) - 8'sd1; d = byte'($urandom_range(0, 2)) - 8'sd1; end
        default: ;
      endcase
      issue(a, b, c, d);
    end

    repeat (25) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
